uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between N_REQ byte-stream requesters, e.g. the game-state reporter and the debug console.
- Grants in round-robin order and locks the grant for a whole packet, which ends on the byte flagged last.
- Sequences the transmitter's start_tx / tx_ready handshake, so requesters only ever see a simple valid/ack interface.
- Sits between the requesters and the UART top-level's TX port.

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding and byte width used by the arbiter and its interface.
package uart_tx_arbiter_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_GAP,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the transmit arbiter.
// slave = the arbiter, master = requesters plus UART.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    import uart_tx_arbiter_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        grant;
    logic                    timeout_err;
    logic                    tx_ready;
    logic                    start_tx;
    logic [DATA_W-1:0]       TX_data;

    modport slave (
        input  req, req_data, req_last, tx_ready,
        output ack, grant, timeout_err, start_tx, TX_data
    );

    modport master (
        output req, req_data, req_last, tx_ready,
        input  ack, grant, timeout_err, start_tx, TX_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority select: first set request at or after the
// pointer, wrapping modulo N_REQ; result is one-hot or zero.
module uart_tx_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // Scan from the pointer upward and keep only the first hit.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte-stream requesters,
// round-robin, with the grant locked for a whole packet.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_TIMEOUT = 100000,
    parameter int GAP_CYCLES   = 0
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (HOLD_TIMEOUT > GAP_CYCLES) ?
                             HOLD_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            r_state,  w_state_n;
    logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_n;
    logic              r_lock,   w_lock_n;
    logic [N_REQ-1:0]  r_grant,  w_grant_n;
    logic [PTR_W-1:0]  r_owner,  w_owner_n;
    logic [DATA_W-1:0] r_data,   w_data_n;
    logic              r_last,   w_last_n;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_n;
    logic [N_REQ-1:0]  r_ack,    w_ack_n;
    logic              r_tout,   w_tout_n;

    logic [N_REQ-1:0]  w_pick;
    logic [PTR_W-1:0]  w_pick_idx;
    logic [DATA_W-1:0] w_pick_data;
    logic [DATA_W-1:0] w_own_data;
    logic              w_done;
    logic [PTR_W-1:0]  w_ptr_after;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req (bus.req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick)
    );

    // Index and byte of the picked requester and of the current owner.
    always_comb begin
        w_pick_idx  = '0;
        w_pick_data = '0;
        w_own_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx  = PTR_W'(i);
                w_pick_data = bus.req_data[i*DATA_W +: DATA_W];
            end
            if (int'(r_owner) == i) begin
                w_own_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        w_ptr_after = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + 1'b1;
    end

    // Next-state logic: byte sequencing, packet lock and hold timeout.
    always_comb begin
        w_state_n  = r_state;
        w_rr_ptr_n = r_rr_ptr;
        w_lock_n   = r_lock;
        w_grant_n  = r_grant;
        w_owner_n  = r_owner;
        w_data_n   = r_data;
        w_last_n   = r_last;
        w_cnt_n    = r_cnt;
        w_ack_n    = '0;
        w_tout_n   = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req && bus.tx_ready) begin
                    w_grant_n = w_pick;
                    w_owner_n = w_pick_idx;
                    w_data_n  = w_pick_data;
                    w_last_n  = bus.req_last[w_pick_idx];
                    w_ack_n   = w_pick;
                    w_state_n = ST_START;
                end
            end
            ST_START: begin
                if (!bus.tx_ready) w_state_n = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.tx_ready) begin
                    if (GAP_CYCLES > 0) begin
                        w_cnt_n   = '0;
                        w_state_n = ST_GAP;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) w_done = 1'b1;
                else                   w_cnt_n = r_cnt + 1'b1;
            end
            ST_HOLD: begin
                if (bus.req[r_owner]) begin
                    w_data_n  = w_own_data;
                    w_last_n  = bus.req_last[r_owner];
                    w_ack_n   = r_grant;
                    w_cnt_n   = '0;
                    w_state_n = ST_START;
                end else if (r_cnt == HOLD_LAST) begin
                    w_tout_n   = 1'b1;
                    w_grant_n  = '0;
                    w_lock_n   = 1'b0;
                    w_rr_ptr_n = w_ptr_after;
                    w_cnt_n    = '0;
                    w_state_n  = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_done) begin
            w_cnt_n = '0;
            if (r_last) begin
                w_grant_n  = '0;
                w_lock_n   = 1'b0;
                w_rr_ptr_n = w_ptr_after;
                w_state_n  = ST_IDLE;
            end else begin
                w_lock_n  = 1'b1;
                w_state_n = ST_HOLD;
            end
        end
    end

    // State register; reset abandons any in-flight byte at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_lock   <= 1'b0;
            r_grant  <= '0;
            r_owner  <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_cnt    <= '0;
            r_ack    <= '0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_rr_ptr <= w_rr_ptr_n;
            r_lock   <= w_lock_n;
            r_grant  <= w_grant_n;
            r_owner  <= w_owner_n;
            r_data   <= w_data_n;
            r_last   <= w_last_n;
            r_cnt    <= w_cnt_n;
            r_ack    <= w_ack_n;
            r_tout   <= w_tout_n;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.grant       = r_grant;
    assign bus.timeout_err = r_tout;
    assign bus.start_tx    = (r_state == ST_START);
    assign bus.TX_data     = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART ready model.
// Requesters are driven on the falling edge; outputs sampled there too.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;

    uart_tx_arbiter_if #(.N_REQ(4)) bus();

    uart_tx_arbiter #(
        .N_REQ        (4),
        .HOLD_TIMEOUT (50),
        .GAP_CYCLES   (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic       model_rdy  = 1'b1;
    logic       model_busy = 1'b0;
    logic       busy_force = 1'b0;
    logic [7:0] started[$];
    int         ack_cnt[4];
    logic [3:0] prev_ack = '0;

    assign bus.tx_ready = model_rdy && !busy_force;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART model: drops ready 2 clocks after a start, raises it 20 later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.start_tx && model_rdy) begin
                model_busy = 1'b1;
                started.push_back(bus.TX_data);
                repeat (2) @(posedge clk);
                #1 model_rdy = 1'b0;
                repeat (20) @(posedge clk);
                #1 model_rdy = 1'b1;
                model_busy = 1'b0;
            end
        end
    end

    // Ack monitor: one-hot, inside grant, never two cycles in a row.
    always @(negedge clk) begin
        if (reset) begin
            prev_ack = '0;
        end else begin
            if (|bus.ack) begin
                chk("ack_onehot", $countones(bus.ack), 1);
                chk("ack_in_grant", bus.ack & ~bus.grant, 0);
                chk("ack_single", bus.ack & prev_ack, 0);
                for (int i = 0; i < 4; i++)
                    if (bus.ack[i]) ack_cnt[i]++;
            end
            prev_ack = bus.ack;
        end
    end

    task automatic set_req(input int idx, input logic v,
                           input logic [7:0] d, input logic l);
        bus.req[idx]            = v;
        bus.req_data[idx*8 +: 8] = d;
        bus.req_last[idx]       = l;
    endtask

    task automatic do_reset();
        int n;
        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        busy_force   = 1'b0;
        n = 0;
        while (model_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        started.delete();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int idx, input string tag);
        int n = 0;
        while (!bus.ack[idx] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.ack[idx], 1);
    endtask

    task automatic wait_ready(input logic v, input string tag);
        int n = 0;
        while (bus.tx_ready !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.tx_ready, v);
    endtask

    task automatic wait_grant0(input string tag);
        int n = 0;
        while (bus.grant !== 4'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.grant, 0);
    endtask

    task automatic wait_started(input int num, input string tag);
        int n = 0;
        while (started.size() < num && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, started.size(), num);
    endtask

    initial begin
        logic [7:0] exp_rr[5];
        logic [7:0] exp_pk[4];
        int         n;

        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", bus.ack, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_start", bus.start_tx, 0);
        chk("rst_data", bus.TX_data, 0);
        chk("rst_tout", bus.timeout_err, 0);
        do_reset();

        // 1: single byte from requester 1
        set_req(1, 1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        wait_ack(1, "t1_ack_wait");
        chk("t1_ack", bus.ack, 4'b0010);
        chk("t1_grant", bus.grant, 4'b0010);
        chk("t1_start", bus.start_tx, 1);
        chk("t1_data", bus.TX_data, 8'hA5);
        set_req(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t1_ack_pulse", bus.ack, 0);
        wait_ready(1'b0, "t1_rdy_low");
        chk("t1_start_held", bus.start_tx, 1);
        @(negedge clk);
        chk("t1_start_drop", bus.start_tx, 0);
        wait_grant0("t1_grant_clr");
        chk("t1_rr_ptr", dut.r_rr_ptr, 2);
        chk("t1_nstart", started.size(), 1);
        chk("t1_ack_cnt", ack_cnt[1], 1);
        if (started.size() > 0) chk("t1_sent", started[0], 8'hA5);

        // 2: all four requesting single-byte packets
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
        exp_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        wait_started(5, "t2_nstart");
        bus.req = '0;
        for (int k = 0; k < 5; k++)
            if (k < started.size()) chk("t2_order", started[k], exp_rr[k]);
        wait_grant0("t2_grant_clr");

        // 3: three-byte packet from 0 while 2 waits
        do_reset();
        set_req(2, 1'b1, 8'h22, 1'b1);
        set_req(0, 1'b1, 8'h01, 1'b0);
        @(negedge clk);
        wait_ack(0, "t3_ack_b1");
        set_req(0, 1'b1, 8'h02, 1'b0);
        @(negedge clk);
        wait_ack(0, "t3_ack_b2");
        set_req(0, 1'b1, 8'h03, 1'b1);
        @(negedge clk);
        wait_ack(0, "t3_ack_b3");
        set_req(0, 1'b0, 8'h00, 1'b0);
        chk("t3_no_ack2", ack_cnt[2], 0);
        @(negedge clk);
        wait_ack(2, "t3_ack_r2");
        set_req(2, 1'b0, 8'h00, 1'b0);
        exp_pk = '{8'h01, 8'h02, 8'h03, 8'h22};
        wait_started(4, "t3_nstart");
        for (int k = 0; k < 4; k++)
            if (k < started.size()) chk("t3_order", started[k], exp_pk[k]);
        wait_grant0("t3_grant_clr");

        // 4: lock released by hold timeout, pending req 0 served next
        do_reset();
        set_req(3, 1'b1, 8'h33, 1'b0);
        @(negedge clk);
        wait_ack(3, "t4_ack3");
        set_req(3, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h44, 1'b1);
        wait_ready(1'b0, "t4_rdy_low");
        wait_ready(1'b1, "t4_rdy_high");
        // DUT samples the raised ready on the next edge, entering HOLD;
        // the timeout pulse follows 50 edges later.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.timeout_err && n < 200);
        chk("t4_tout_delay", n, 51);
        chk("t4_grant_clr", bus.grant, 0);
        chk("t4_no_ack0", ack_cnt[0], 0);
        @(negedge clk);
        chk("t4_tout_pulse", bus.timeout_err, 0);
        chk("t4_next_ack", bus.ack, 4'b0001);
        chk("t4_next_grant", bus.grant, 4'b0001);
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_grant0("t4_grant_end");

        // 5: external busy holds off the grant
        do_reset();
        busy_force = 1'b1;
        set_req(2, 1'b1, 8'h55, 1'b1);
        repeat (10) @(negedge clk);
        chk("t5_no_ack", ack_cnt[2], 0);
        chk("t5_no_start", bus.start_tx, 0);
        chk("t5_no_grant", bus.grant, 0);
        busy_force = 1'b0;
        @(negedge clk);
        chk("t5_ack", bus.ack, 4'b0100);
        chk("t5_start", bus.start_tx, 1);
        set_req(2, 1'b0, 8'h00, 1'b0);
        wait_grant0("t5_grant_clr");

        // 6: async reset while start_tx is high
        do_reset();
        set_req(1, 1'b1, 8'h66, 1'b1);
        @(negedge clk);
        wait_ack(1, "t6_ack1");
        chk("t6_start_pre", bus.start_tx, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_start", bus.start_tx, 0);
        chk("t6_rst_grant", bus.grant, 0);
        chk("t6_rst_ack", bus.ack, 0);
        @(negedge clk);
        do_reset();
        set_req(1, 1'b1, 8'h77, 1'b1);
        @(negedge clk);
        wait_ack(1, "t6_ack_fresh");
        chk("t6_data", bus.TX_data, 8'h77);
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_started(1, "t6_nstart");
        if (started.size() > 0) chk("t6_sent", started[0], 8'h77);
        wait_grant0("t6_grant_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench did not finish");
    end

endmodule
